// File: rtl/dmem_ctrl.sv
// Round-robin CPU/debug arbiter and sequencer for a single-port, synchronous-read word memory.
// Sub-word stores are handled as read-modify-write; sub-word loads are lane-extracted and extended.
module dmem_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [31:0]              cpu_addr,
    input  logic [1:0]               cpu_size,
    input  logic                     cpu_unsigned,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_ack,
    output logic                     cpu_err,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [31:0]              dbg_addr,
    input  logic [1:0]               dbg_size,
    input  logic                     dbg_unsigned,
    input  logic [DATA_WIDTH-1:0]    dbg_wdata,
    output logic                     dbg_ack,
    output logic                     dbg_err,
    output logic [DATA_WIDTH-1:0]    dbg_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

    state_t                   state_reg, state_next;
    logic                     last_dbg_reg;
    logic                     gnt_dbg_reg;
    logic                     we_reg;
    logic                     uns_reg;
    logic                     err_reg;
    logic [1:0]               size_reg;
    logic [1:0]               lane_reg;
    logic [ADDRESS_WIDTH-1:0] idx_reg;
    logic [DATA_WIDTH-1:0]    wr_word_reg;
    logic [DATA_WIDTH-1:0]    cpu_rdata_reg;
    logic [DATA_WIDTH-1:0]    dbg_rdata_reg;

    logic                     any_req;
    logic                     pick_dbg;
    logic                     s_we;
    logic                     s_uns;
    logic                     s_err;
    logic [31:0]              s_addr;
    logic [1:0]               s_size;
    logic [DATA_WIDTH-1:0]    s_wdata;
    logic [7:0]               sel_byte;
    logic [15:0]              sel_half;
    logic [DATA_WIDTH-1:0]    load_val;
    logic [DATA_WIDTH-1:0]    merged;
    logic                     unused_addr_hi;

    // On a tie the port that was not granted last wins.
    always_comb begin
        any_req  = cpu_req | dbg_req;
        pick_dbg = dbg_req & (~cpu_req | ~last_dbg_reg);
        if (pick_dbg) begin
            s_we    = dbg_we;
            s_addr  = dbg_addr;
            s_size  = dbg_size;
            s_uns   = dbg_unsigned;
            s_wdata = dbg_wdata;
        end else begin
            s_we    = cpu_we;
            s_addr  = cpu_addr;
            s_size  = cpu_size;
            s_uns   = cpu_unsigned;
            s_wdata = cpu_wdata;
        end
        s_err = (s_size == 2'b11)
              | ((s_size == 2'b01) & s_addr[0])
              | ((s_size == 2'b10) & (|s_addr[1:0]));
    end

    // Address bits above the array are deliberately dropped so accesses wrap.
    assign unused_addr_hi = ^s_addr[31:ADDRESS_WIDTH+2];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    if (s_err)                state_next = DONE;
                    else if (!s_we)           state_next = READ;
                    else if (s_size == 2'b10) state_next = WRITE;
                    else                      state_next = READ;
                end
            end
            READ:    state_next = MERGE;
            MERGE:   state_next = we_reg ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (lane_reg)
            2'd0:    sel_byte = mem_rd[7:0];
            2'd1:    sel_byte = mem_rd[15:8];
            2'd2:    sel_byte = mem_rd[23:16];
            default: sel_byte = mem_rd[31:24];
        endcase
        sel_half = lane_reg[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (size_reg)
            2'b00:   load_val = {{24{~uns_reg & sel_byte[7]}}, sel_byte};
            2'b01:   load_val = {{16{~uns_reg & sel_half[15]}}, sel_half};
            default: load_val = mem_rd;
        endcase
    end

    // Store data stays right-aligned in wr_word_reg until MERGE folds it into the read word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic byte_hit;
            logic half_hit;
            assign byte_hit = (size_reg == 2'b00) && (lane_reg == LANE);
            assign half_hit = (size_reg == 2'b01) && (lane_reg[1] == LANE[1]);
            assign merged[gi*8 +: 8] = byte_hit ? wr_word_reg[7:0]
                                     : half_hit ? wr_word_reg[(gi%2)*8 +: 8]
                                     : mem_rd[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_dbg_reg  <= 1'b1;
            gnt_dbg_reg   <= 1'b0;
            we_reg        <= 1'b0;
            uns_reg       <= 1'b0;
            err_reg       <= 1'b0;
            size_reg      <= 2'b00;
            lane_reg      <= 2'b00;
            idx_reg       <= '0;
            wr_word_reg   <= '0;
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        gnt_dbg_reg  <= pick_dbg;
                        last_dbg_reg <= pick_dbg;
                        we_reg       <= s_we;
                        uns_reg      <= s_uns;
                        err_reg      <= s_err;
                        size_reg     <= s_size;
                        lane_reg     <= s_addr[1:0];
                        idx_reg      <= s_addr[ADDRESS_WIDTH+1:2];
                        wr_word_reg  <= s_wdata;
                    end
                end
                MERGE: begin
                    if (we_reg)           wr_word_reg   <= merged;
                    else if (gnt_dbg_reg) dbg_rdata_reg <= load_val;
                    else                  cpu_rdata_reg <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign cpu_ack   = (state_reg == DONE) & ~gnt_dbg_reg;
    assign dbg_ack   = (state_reg == DONE) &  gnt_dbg_reg;
    assign cpu_err   = cpu_ack & err_reg;
    assign dbg_err   = dbg_ack & err_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign dbg_rdata = dbg_rdata_reg;
    assign mem_a     = idx_reg;
    assign mem_we    = (state_reg == WRITE);
    assign mem_wd    = wr_word_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed vector bench for dmem_ctrl: a behavioural synchronous-read memory,
// a transaction table, and hand sequences for arbitration and mid-operation reset.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_unsigned;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_ack, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_unsigned;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [1:0]  dbg_size;
    logic        dbg_ack, dbg_err;
    logic [31:0] dbg_rdata;
    logic [9:0]  mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];
    int          wr_cnt;
    logic [9:0]  last_wr_a;
    int          pass_cnt;
    int          total_cnt;

    dmem_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_size(dbg_size),
        .dbg_unsigned(dbg_unsigned), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory with one-cycle registered read; this process alone owns the array.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[7] = 32'h7777_0007;
        mem[8] = 32'h8888_0008;
        mem_rd = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_a] <= mem_wd;
            mem_rd <= mem[mem_a];
        end
    end

    initial begin
        wr_cnt    = 0;
        last_wr_a = '0;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                wr_cnt    = wr_cnt + 1;
                last_wr_a = mem_a;
            end
        end
    end

    typedef struct {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_idx;
        logic [31:0] exp_word;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt = pass_cnt + 1;
    endtask

    task automatic do_txn(input vec_t v, input int id);
        logic [31:0] other_before;
        int          lat;
        int          w0;
        bit          got;
        bit          other_ack;
        @(negedge clk);
        other_before = v.dbg ? cpu_rdata : dbg_rdata;
        w0 = wr_cnt;
        if (v.dbg) begin
            dbg_we = v.we; dbg_addr = v.addr; dbg_size = v.size;
            dbg_unsigned = v.uns; dbg_wdata = v.wdata; dbg_req = 1'b1;
        end else begin
            cpu_we = v.we; cpu_addr = v.addr; cpu_size = v.size;
            cpu_unsigned = v.uns; cpu_wdata = v.wdata; cpu_req = 1'b1;
        end
        lat = 0; got = 1'b0; other_ack = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (v.dbg ? dbg_ack : cpu_ack) got = 1'b1;
            if (v.dbg ? cpu_ack : dbg_ack) other_ack = 1'b1;
        end
        $display("txn %0d %s we=%0b addr=%h size=%0d lat=%0d err=%0b rdata=%h", id,
                 v.dbg ? "dbg" : "cpu", v.we, v.addr, v.size, lat,
                 v.dbg ? dbg_err : cpu_err, v.dbg ? dbg_rdata : cpu_rdata);
        check($sformatf("v%0d ack latency", id), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d err", id), {31'h0, (v.dbg ? dbg_err : cpu_err)}, {31'h0, v.exp_err});
        if (!v.we && !v.exp_err)
            check($sformatf("v%0d rdata", id), v.dbg ? dbg_rdata : cpu_rdata, v.exp_rdata);
        check($sformatf("v%0d other rdata kept", id), v.dbg ? cpu_rdata : dbg_rdata, other_before);
        check($sformatf("v%0d other ack quiet", id), {31'h0, other_ack}, 32'h0);
        check($sformatf("v%0d write count", id), 32'(wr_cnt - w0),
              (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.we && !v.exp_err)
            check($sformatf("v%0d write index", id), {22'h0, last_wr_a}, 32'(v.exp_idx));
        check($sformatf("v%0d mem word", id), mem[v.exp_idx], v.exp_word);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        int   ack_cyc [0:3];
        int   ack_who [0:3];
        int   n_ack;
        int   cyc;
        int   w0;
        bit   stray_ack;
        vec_t rv;

        pass_cnt = 0; total_cnt = 0;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_size = 0; cpu_unsigned = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_size = 0; dbg_unsigned = 0; dbg_wdata = 0;

        //           dbg   we    addr            size   uns   wdata          err   lat rdata          idx word
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 32'h0,         4, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b0, 3, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 2, 32'h0,         4, 32'h1122_3344};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,         1'b0, 3, 32'h0000_0011, 4, 32'h1122_3344};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0011, 2'b00, 1'b0, 32'hABCD_EFFF, 1'b0, 4, 32'h0,         4, 32'h1122_FF44};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_0010, 2'b01, 1'b0, 32'h0,         1'b0, 3, 32'hFFFF_FF44, 4, 32'h1122_FF44};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0010, 2'b01, 1'b1, 32'h0,         1'b0, 3, 32'h0000_FF44, 4, 32'h1122_FF44};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0011, 2'b00, 1'b0, 32'h0,         1'b0, 3, 32'hFFFF_FFFF, 4, 32'h1122_FF44};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0011, 2'b00, 1'b1, 32'h0,         1'b0, 3, 32'h0000_00FF, 4, 32'h1122_FF44};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0011, 2'b01, 1'b0, 32'h0,         1'b1, 1, 32'h0,         4, 32'h1122_FF44};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0012, 2'b10, 1'b0, 32'h0,         1'b1, 1, 32'h0,         4, 32'h1122_FF44};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 2'b11, 1'b0, 32'h0,         1'b1, 1, 32'h0,         4, 32'h1122_FF44};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_0012, 2'b01, 1'b0, 32'h1234_BEEF, 1'b0, 4, 32'h0,         4, 32'hBEEF_FF44};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0012, 2'b01, 1'b1, 32'h0,         1'b0, 3, 32'h0000_BEEF, 4, 32'hBEEF_FF44};
        vecs[14] = '{1'b0, 1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'h0,         1'b0, 3, 32'hFFFF_BEEF, 4, 32'hBEEF_FF44};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_0010, 2'b00, 1'b0, 32'h0000_0080, 1'b0, 4, 32'h0,         4, 32'hBEEF_FF80};
        vecs[16] = '{1'b0, 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0,         1'b0, 3, 32'hFFFF_FF80, 4, 32'hBEEF_FF80};
        vecs[17] = '{1'b1, 1'b1, 32'h0000_0012, 2'b00, 1'b0, 32'h0000_005A, 1'b0, 4, 32'h0,         4, 32'hBE5A_FF80};
        vecs[18] = '{1'b1, 1'b0, 32'h0000_0012, 2'b00, 1'b1, 32'h0,         1'b0, 3, 32'h0000_005A, 4, 32'hBE5A_FF80};
        vecs[19] = '{1'b1, 1'b1, 32'h0000_1000, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 2, 32'h0,         0, 32'hCAFE_F00D};
        vecs[20] = '{1'b0, 1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0,         1'b0, 3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D};
        vecs[21] = '{1'b0, 1'b1, 32'h0000_0010, 2'b01, 1'b0, 32'h0000_7FFF, 1'b0, 4, 32'h0,         4, 32'hBE5A_7FFF};
        vecs[22] = '{1'b0, 1'b0, 32'h0000_0010, 2'b01, 1'b0, 32'h0,         1'b0, 3, 32'h0000_7FFF, 4, 32'hBE5A_7FFF};
        vecs[23] = '{1'b0, 1'b1, 32'h0000_0010, 2'b11, 1'b0, 32'h0,         1'b1, 1, 32'h0,         4, 32'hBE5A_7FFF};
        vecs[24] = '{1'b0, 1'b0, 32'h0040_1000, 2'b10, 1'b0, 32'h0,         1'b0, 3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D};
        vecs[25] = '{1'b1, 1'b1, 32'h0000_0013, 2'b01, 1'b0, 32'hFFFF_FFFF, 1'b1, 1, 32'h0,         4, 32'hBE5A_7FFF};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset ack/err/we", {28'h0, cpu_ack, cpu_err, dbg_ack, dbg_err} | {31'h0, mem_we}, 32'h0);
        check("reset mem_a", {22'h0, mem_a}, 32'h0);
        check("reset mem_wd", mem_wd, 32'h0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        check("reset dbg_rdata", dbg_rdata, 32'h0);

        // Both ports request continuously: grants must alternate starting with the CPU.
        cpu_we = 0; cpu_addr = 32'h1C; cpu_size = 2'b10; cpu_unsigned = 0;
        dbg_we = 0; dbg_addr = 32'h20; dbg_size = 2'b10; dbg_unsigned = 0;
        cpu_req = 1; dbg_req = 1;
        n_ack = 0; cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                ack_cyc[n_ack] = cyc;
                ack_who[n_ack] = dbg_ack ? 1 : 0;
                $display("txn arb ack %0d port=%s cycle=%0d", n_ack, dbg_ack ? "dbg" : "cpu", cyc);
                n_ack++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        check("arb ack count", 32'(n_ack), 32'd4);
        for (int i = 0; i < n_ack; i++) begin
            check($sformatf("arb grant %0d", i), 32'(ack_who[i]), 32'(i % 2));
            check($sformatf("arb cycle %0d", i), 32'(ack_cyc[i]), 32'(3 + 4 * i));
        end
        check("arb cpu_rdata", cpu_rdata, 32'h7777_0007);
        check("arb dbg_rdata", dbg_rdata, 32'h8888_0008);

        for (int i = 0; i < NV; i++) do_txn(vecs[i], i);

        // Reset during MERGE of a byte store: nothing written, no ack, outputs cleared.
        @(negedge clk);
        w0 = wr_cnt;
        cpu_we = 1; cpu_addr = 32'h1D; cpu_size = 2'b00; cpu_unsigned = 0; cpu_wdata = 32'h99;
        cpu_req = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("midrst ack/err/we", {28'h0, cpu_ack, cpu_err, dbg_ack, dbg_err} | {31'h0, mem_we}, 32'h0);
        check("midrst mem_a", {22'h0, mem_a}, 32'h0);
        check("midrst mem_wd", mem_wd, 32'h0);
        check("midrst cpu_rdata", cpu_rdata, 32'h0);
        check("midrst dbg_rdata", dbg_rdata, 32'h0);
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) stray_ack = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) stray_ack = 1'b1;
        end
        $display("txn midrst byte store aborted writes=%0d", wr_cnt - w0);
        check("midrst no ack", {31'h0, stray_ack}, 32'h0);
        check("midrst no write", 32'(wr_cnt - w0), 32'h0);
        check("midrst mem kept", mem[7], 32'h7777_0007);

        rv = '{1'b0, 1'b1, 32'h0000_001D, 2'b00, 1'b0, 32'h0000_0099, 1'b0, 4, 32'h0, 7, 32'h7777_9907};
        do_txn(rv, 100);
        rv = '{1'b1, 1'b0, 32'h0000_001D, 2'b00, 1'b1, 32'h0, 1'b0, 3, 32'h0000_0099, 7, 32'h7777_9907};
        do_txn(rv, 101);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
